// File: rtl/prog_mod_counter.sv
// prog_mod_counter: runtime-programmable modulo counter with up/down count,
// synchronous load with clamp, shadowed modulus applied only at wrap or load,
// early-warning max_tick and a wrap pulse for cascading.
// Optional compare output enabled by defining PROG_MOD_COUNTER_CMP_EN.
module prog_mod_counter #(
    parameter int unsigned N         = 10,
    parameter int unsigned M_DEFAULT = 640,
    parameter int unsigned TICK_LEAD = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clk_en,
    input  logic         pause,
    input  logic         dir,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         mod_wr,
    input  logic [N-1:0] mod_in,
    output logic [N-1:0] q,
    output logic         max_tick,
    output logic         wrap,
`ifdef PROG_MOD_COUNTER_CMP_EN
    input  logic [N-1:0] cmp_val,
    output logic         cmp_match,
`endif
    output logic [N-1:0] mod_active
);

    // Modulus is held in N+1 bits so that 2^N is representable.
    localparam logic [N:0]   MOD_RST = (N+1)'(M_DEFAULT);
    localparam logic [N:0]   ONE_W   = (N+1)'(1);
    localparam logic [N+1:0] LEAD    = (N+2)'(TICK_LEAD);
    localparam logic [N-1:0] ONE_N   = N'(1);
    localparam logic [N-1:0] TWO_N   = N'(2);

    logic [N-1:0] cnt_q, cnt_d;
    logic [N:0]   mod_q, mod_d;
    logic [N:0]   pend_q, pend_d;
    logic         pend_vld_q, pend_vld_d;

    logic         adv;
    logic         at_term;
    logic         apply;
    logic [N-1:0] term;
    logic [N:0]   mod_m1;
    logic [N:0]   mod_next;
    logic [N:0]   next_m1;
    logic         tick_ok;
    logic [N+1:0] up_tgt;

    assign adv        = clk_en & ~pause & ~load;
    assign mod_m1     = mod_q - ONE_W;
    assign q          = cnt_q;
    assign mod_active = mod_q[N-1:0];

    // Terminal count, wrap pulse and the modulus that will be in force after this edge.
    always_comb begin
        term     = dir ? '0 : mod_m1[N-1:0];
        at_term  = (cnt_q == term);
        wrap     = adv & at_term;
        apply    = load | wrap;
        mod_next = (apply & pend_vld_q) ? pend_q : mod_q;
        next_m1  = mod_next - ONE_W;
    end

    // Early-warning tick, suppressed entirely when the lead reaches the modulus.
    always_comb begin
        tick_ok  = ({1'b0, mod_q} > LEAD);
        up_tgt   = {1'b0, mod_m1} - LEAD;
        max_tick = 1'b0;
        if (tick_ok) begin
            if (dir) begin
                max_tick = ({2'b00, cnt_q} == LEAD);
            end else begin
                max_tick = ({2'b00, cnt_q} == up_tgt);
            end
        end
    end

    // Next count and modulus shadowing: load beats advance beats hold.
    always_comb begin
        cnt_d      = cnt_q;
        mod_d      = mod_next;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q & ~apply;

        if (load) begin
            cnt_d = ({1'b0, load_val} >= mod_next) ? next_m1[N-1:0] : load_val;
        end else if (adv) begin
            if (at_term) begin
                cnt_d = dir ? next_m1[N-1:0] : '0;
            end else begin
                cnt_d = dir ? (cnt_q - ONE_N) : (cnt_q + ONE_N);
            end
        end

        // A write coinciding with apply lands after the old pending was consumed.
        if (mod_wr && (mod_in >= TWO_N)) begin
            pend_d     = {1'b0, mod_in};
            pend_vld_d = 1'b1;
        end
    end

    // State registers with asynchronous reset; the pending modulus is discarded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            mod_q      <= MOD_RST;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            mod_q      <= mod_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

`ifdef PROG_MOD_COUNTER_CMP_EN
    logic cmp_match_q;

    assign cmp_match = cmp_match_q;

    // Registered compare against the next count, so it is high exactly while q == cmp_val.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmp_match_q <= 1'b0;
        end else begin
            cmp_match_q <= (cnt_d == cmp_val);
        end
    end
`endif

endmodule

// File: tb/tb_prog_mod_counter.sv
// Self-checking bench for prog_mod_counter: integer reference model plus
// directed literal expectations and a randomized phase.
module tb_prog_mod_counter;

    localparam int N  = 10;
    localparam int MD = 640;
    localparam int TL = 1;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         clk_en, pause, dir, load, mod_wr;
    logic [N-1:0] load_val, mod_in;
    logic [N-1:0] q, mod_active;
    logic         max_tick, wrap;

    always #5 clk = ~clk;

    prog_mod_counter #(.N(N), .M_DEFAULT(MD), .TICK_LEAD(TL)) dut (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .pause(pause),
        .dir(dir), .load(load), .load_val(load_val), .mod_wr(mod_wr),
        .mod_in(mod_in), .q(q), .max_tick(max_tick), .wrap(wrap),
        .mod_active(mod_active)
    );

    // Reference model state: count, modulus, pending modulus and its valid flag.
    int mq, mm, mp;
    bit mpv;
    int nq, nm, np;
    bit npv;
    bit m_adv, m_wrap, m_apply, m_tick;
    int m_T, m_newmod;

    always_comb begin
        m_adv    = clk_en && !pause && !load;
        m_T      = dir ? 0 : mm - 1;
        m_wrap   = m_adv && (mq == m_T);
        m_apply  = load || m_wrap;
        m_newmod = (m_apply && mpv) ? mp : mm;
        m_tick   = (TL < mm) && (dir ? (mq == TL) : (mq == mm - 1 - TL));
        nq = mq;
        if (load)        nq = (int'(load_val) >= m_newmod) ? m_newmod - 1 : int'(load_val);
        else if (m_wrap) nq = dir ? m_newmod - 1 : 0;
        else if (m_adv)  nq = dir ? mq - 1 : mq + 1;
        nm  = m_newmod;
        np  = mp;
        npv = mpv && !m_apply;
        if (mod_wr && int'(mod_in) >= 2) begin
            np  = int'(mod_in);
            npv = 1'b1;
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq <= 0; mm <= MD; mp <= 0; mpv <= 1'b0;
        end else begin
            mq <= nq; mm <= nm; mp <= np; mpv <= npv;
        end
    end

    // Literal expectations posted by the stimulus; -1 means "not checked".
    bit    lit_on = 1'b0;
    string lit_name = "";
    int    lit_q, lit_mod, lit_wrap, lit_tick;

    int total = 0;
    int bad   = 0;

    // Compare process: model vs DUT every cycle, plus any posted literal.
    initial begin
        forever begin
            @(negedge clk);
            total++;
            if (int'(q) != mq || int'(mod_active) != (mm % (1 << N)) ||
                wrap !== m_wrap || max_tick !== m_tick) begin
                bad++;
                $display("FAIL model t=%0t q got=%0d want=%0d mod got=%0d want=%0d wrap got=%0b want=%0b tick got=%0b want=%0b",
                         $time, q, mq, mod_active, mm % (1 << N), wrap, m_wrap, max_tick, m_tick);
            end
            if (lit_on) begin
                if (lit_q >= 0) begin
                    total++;
                    if (int'(q) != lit_q) begin
                        bad++;
                        $display("FAIL %s q got=%0d want=%0d", lit_name, q, lit_q);
                    end
                end
                if (lit_mod >= 0) begin
                    total++;
                    if (int'(mod_active) != lit_mod) begin
                        bad++;
                        $display("FAIL %s mod_active got=%0d want=%0d", lit_name, mod_active, lit_mod);
                    end
                end
                if (lit_wrap >= 0) begin
                    total++;
                    if (int'(wrap) != lit_wrap) begin
                        bad++;
                        $display("FAIL %s wrap got=%0b want=%0d", lit_name, wrap, lit_wrap);
                    end
                end
                if (lit_tick >= 0) begin
                    total++;
                    if (int'(max_tick) != lit_tick) begin
                        bad++;
                        $display("FAIL %s max_tick got=%0b want=%0d", lit_name, max_tick, lit_tick);
                    end
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            lit_on = 1'b0;
        end
    endtask

    task automatic expect_lit(input string nm, input int eq, input int em, input int ew, input int et);
        lit_name = nm; lit_q = eq; lit_mod = em; lit_wrap = ew; lit_tick = et;
        lit_on = 1'b1;
    endtask

    task automatic idle_inputs();
        clk_en = 1'b0; pause = 1'b0; dir = 1'b0; load = 1'b0; mod_wr = 1'b0;
        load_val = '0; mod_in = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        expect_lit("reset", 0, 640, 0, 0);
        tick(2);
        reset_n = 1'b1;

        // Up count over a full period.
        do_reset();
        clk_en = 1'b1;
        tick(638); expect_lit("up_638", 638, 640, 0, 1);
        tick();    expect_lit("up_639", 639, 640, 1, 0);
        tick();    expect_lit("up_wrap0", 0, 640, 0, 0);
        tick(2);

        // Down count from reset.
        do_reset();
        dir = 1'b1; clk_en = 1'b1;
        expect_lit("dn_first", 0, 640, 1, 0);
        tick();    expect_lit("dn_639", 639, 640, 0, 0);
        tick(638); expect_lit("dn_1", 1, 640, 0, 1);
        tick(2);

        // Pause then disable, then resume.
        do_reset();
        clk_en = 1'b1;
        tick(100);
        pause = 1'b1;
        expect_lit("pause", 100, -1, 0, -1);
        repeat (5) begin
            tick(); expect_lit("pause", 100, -1, 0, -1);
        end
        pause = 1'b0; clk_en = 1'b0;
        repeat (3) begin
            tick(); expect_lit("disabled", 100, -1, 0, -1);
        end
        clk_en = 1'b1;
        tick(); expect_lit("resume", 101, -1, -1, -1);
        tick();

        // Shadowed modulus applied only at wrap.
        do_reset();
        clk_en = 1'b1;
        tick(10);
        mod_wr = 1'b1; mod_in = 10'd800;
        tick();
        mod_wr = 1'b0;
        expect_lit("shadow_hold", 11, 640, 0, 0);
        tick(628); expect_lit("shadow_wrap", 639, 640, 1, 0);
        tick();    expect_lit("shadow_applied", 0, 800, 0, 0);
        tick(798); expect_lit("m800_tick", 798, 800, 0, 1);
        tick();    expect_lit("m800_wrap", 799, 800, 1, 0);
        tick(2);

        // Loads: clamp, load under pause, load applies pending.
        do_reset();
        load = 1'b1; load_val = 10'd700;
        tick(); load = 1'b0;
        expect_lit("load_clamp", 639, 640, 0, 0);
        pause = 1'b1; load = 1'b1; load_val = 10'd5;
        tick(); load = 1'b0; pause = 1'b0;
        expect_lit("load_paused", 5, 640, -1, -1);
        mod_wr = 1'b1; mod_in = 10'd100;
        tick();
        mod_in = 10'd1;
        tick(); mod_wr = 1'b0;
        expect_lit("pend_hold", 5, 640, -1, -1);
        load = 1'b1; load_val = 10'd150;
        tick(); load = 1'b0;
        expect_lit("load_apply", 99, 100, -1, -1);
        tick(2);

        // Asynchronous reset mid-count with a pending modulus.
        do_reset();
        clk_en = 1'b1;
        tick(5);
        mod_wr = 1'b1; mod_in = 10'd300;
        tick(); mod_wr = 1'b0;
        tick(314); expect_lit("pre_arst", 320, 640, 0, 0);
        tick();
        reset_n = 1'b0;
        expect_lit("arst", 0, 640, 0, 0);
        tick();
        reset_n = 1'b1;
        tick(639); expect_lit("post_arst_wrap", 639, 640, 1, 0);
        tick();    expect_lit("post_arst_0", 0, 640, 0, 0);
        tick();

        // Randomized phase.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            reset_n  = ($urandom % 600) != 0;
            clk_en   = ($urandom % 10) != 0;
            pause    = ($urandom % 10) == 0;
            load     = ($urandom % 40) == 0;
            load_val = N'($urandom_range(0, 1023));
            if (($urandom % 100) == 0) dir = ~dir;
            mod_wr   = ($urandom % 30) == 0;
            mod_in   = ($urandom % 2) != 0 ? N'($urandom_range(0, 40)) : N'($urandom_range(0, 1023));
            tick();
        end
        reset_n = 1'b1;
        idle_inputs();
        tick(2);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_mod_counter.md
Name: prog_mod_counter

Overview:
Parametrised, runtime-programmable modulo counter. It is the next-generation replacement for the fixed-modulus pixel/line counters in the video timing and Mandelbrot scan path. It adds up/down counting, a synchronous load, a shadowed runtime modulus that takes effect only at wrap, a configurable early-warning tick, and a wrap pulse for cascading counters (pixel counter into line counter).

Parameters:
N, 10, counter width in bits; all count/modulus buses are N bits.
M_DEFAULT, 640, modulus after reset; legal range 2..2^N.
TICK_LEAD, 1, number of steps before the terminal count at which max_tick asserts.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
clk_en  in  1  count enable.
pause  in  1  hold count; overrides clk_en.
dir  in  1  0 = count up, 1 = count down.
load  in  1  synchronous load strobe.
load_val  in  N  value to load.
mod_wr  in  1  write strobe for the pending modulus.
mod_in  in  N  new modulus.
q  out  N  current count.
max_tick  out  1  early-warning tick.
wrap  out  1  terminal-count-and-advancing pulse, used for cascading.
mod_active  out  N  modulus currently in force.

Behaviour:
- Reset (reset_n low, asynchronous): q=0, mod_active=M_DEFAULT, pending-valid flag=0. Combinational outputs follow from these values.
- adv = clk_en & ~pause & ~load.
- Priority per clock edge, highest first: load, then advance, then hold. Load ignores clk_en and pause.
- Terminal count T:
  - up: T = mod_active-1
  - down: T = 0
- Advance:
  - q != T: q moves +1 (up) or -1 (down).
  - q == T: q wraps to 0 (up) or to mod-1 (down). Here mod is the modulus in force after the wrap (see below).
- wrap = adv & (q==T). Combinational, one cycle per wrap, asserted in the cycle before q wraps.
- max_tick is combinational and independent of clk_en/pause:
  - up: q == mod_active-1-TICK_LEAD
  - down: q == TICK_LEAD
  - If TICK_LEAD >= mod_active, max_tick is constantly 0.
- Modulus shadowing:
  - mod_wr with mod_in >= 2 captures mod_in into the pending register and sets pending-valid.
  - mod_wr with mod_in < 2 is ignored.
  - A later mod_wr before application overwrites the pending value.
  - Pending is applied (mod_active <= pending, pending-valid cleared) on a wrap edge or a load edge only; never mid-count.
  - On a down-count wrap with pending-valid set, q loads new_mod-1.
  - mod_wr in the same cycle as a wrap/load: the old pending (if valid) is applied; the new value becomes pending for the next wrap.
- Load: q <= load_val. If load_val >= modulus (the post-application modulus), q <= modulus-1 (clamp).
- dir change takes effect at the next advance; T and max_tick re-evaluate combinationally immediately.
- Modulus 2^N: represent internally with N+1 bits so that mod_active-1 = all ones; mod_active output is truncated to N bits (reads 0).
- reset_n asserted mid-count or mid-pending: all state returns to reset values immediately; the pending modulus is lost.

Optional Feature:
PROG_MOD_COUNTER_CMP_EN.
- Defined: adds input cmp_val (N bits) and output cmp_match (1 bit), plus a registered cmp_match.
  - cmp_match is set on the edge where the next q equals cmp_val, so it is high exactly while q==cmp_val with no combinational path from q.
  - Reset value 0.
  - Used for sync-pulse start/stop positions.
- Undefined: ports cmp_val and cmp_match are absent; no compare logic is present.

Test Plan:
- Up count, N=10, M_DEFAULT=640, clk_en=1:
  - q runs 0..639 then 0.
  - max_tick high only at q=638.
  - wrap high only at q=639.
- Down count, dir=1 from reset:
  - first advance q=0 -> 639, with wrap high in the q=0 cycle.
  - max_tick at q=1.
- pause=1 at q=100 for 5 cycles, then clk_en=0 for 3 cycles: q stays 100 throughout; wrap stays 0; resumes at 101.
- mod_wr with mod_in=800 at q=10: mod_active stays 640 until the wrap at q=639; next cycle q=0, mod_active=800; next wrap occurs at q=799.
- Load:
  - load_val=700 with mod 640 gives q=639.
  - load with pause=1 still loads.
  - load together with pending=100 and load_val=150 gives mod_active=100, q=99.
- Async reset (reset_n=0) mid-count at q=321 with pending modulus set: q=0 and mod_active=640 without a clock edge; after release, counting restarts from 0 with modulus 640.
